// File: rtl/qft_gate_pkg.sv
// Shared gate codes and fixed-point helpers for the state-vector gate engines.
// The fallback width keeps this file self-contained when the fixed-point header is absent.
`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 8
`endif

package qft_gate_pkg;

    localparam int FP_WIDTH = `TOTAL_WIDTH;
    localparam int FP_FRAC  = 4;

    typedef enum logic [1:0] {
        GATE_I = 2'd0,
        GATE_X = 2'd1,
        GATE_Z = 2'd2,
        GATE_Y = 2'd3
    } gate_e;

    // Two's-complement negate clamped to the w-bit range, so -min maps to +max.
    function automatic logic signed [31:0] sat_neg(input logic signed [31:0] a, input int w);
        logic signed [31:0] min_v;
        min_v = -(32'sd1 <<< (w - 1));
        if (a == min_v) return (32'sd1 <<< (w - 1)) - 32'sd1;
        return -a;
    endfunction

endpackage

// File: rtl/pair_gate_alu.sv
// Combinational single-qubit gate on one amplitude pair (a0 = |..0..>, a1 = |..1..>).
module pair_gate_alu
    import qft_gate_pkg::*;
#(
    parameter int WIDTH = FP_WIDTH
) (
    input  logic        [1:0]       gate_sel,
    input  logic signed [WIDTH-1:0] a0_re,
    input  logic signed [WIDTH-1:0] a0_im,
    input  logic signed [WIDTH-1:0] a1_re,
    input  logic signed [WIDTH-1:0] a1_im,
    output logic signed [WIDTH-1:0] b0_re,
    output logic signed [WIDTH-1:0] b0_im,
    output logic signed [WIDTH-1:0] b1_re,
    output logic signed [WIDTH-1:0] b1_im
);

    logic signed [WIDTH-1:0] n_a0_im, n_a1_re, n_a1_im;

    assign n_a0_im = WIDTH'(sat_neg(32'(a0_im), WIDTH));
    assign n_a1_re = WIDTH'(sat_neg(32'(a1_re), WIDTH));
    assign n_a1_im = WIDTH'(sat_neg(32'(a1_im), WIDTH));

    always_comb begin
        b0_re = a0_re;
        b0_im = a0_im;
        b1_re = a1_re;
        b1_im = a1_im;
        case (gate_e'(gate_sel))
            GATE_X: begin
                b0_re = a1_re;   b0_im = a1_im;
                b1_re = a0_re;   b1_im = a0_im;
            end
            GATE_Z: begin
                b1_re = n_a1_re; b1_im = n_a1_im;
            end
            // Y = [[0,-i],[i,0]]: multiplying by -i / +i is a swap of parts with one negation.
            GATE_Y: begin
                b0_re = a1_im;   b0_im = n_a1_re;
                b1_re = n_a0_im; b1_im = a0_re;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/qubit_gate_engine.sv
// NUM_QUBITS state-vector register with a sequential single-qubit gate sweep,
// one amplitude pair per clock, plus an IDLE-only load port and combinational readout.
module qubit_gate_engine
    import qft_gate_pkg::*;
#(
    parameter  int NUM_QUBITS = 3,
    parameter  int WIDTH      = FP_WIDTH,
    parameter  int FRAC       = FP_FRAC,
    localparam int AW         = NUM_QUBITS,
    localparam int TW         = (NUM_QUBITS > 1) ? $clog2(NUM_QUBITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    input  logic        [AW-1:0]    load_addr,
    input  logic signed [WIDTH-1:0] load_re,
    input  logic signed [WIDTH-1:0] load_im,
    input  logic                    start,
    input  logic        [1:0]       gate_sel,
    input  logic        [TW-1:0]    target,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    input  logic        [AW-1:0]    rd_addr,
    output logic signed [WIDTH-1:0] rd_re,
    output logic signed [WIDTH-1:0] rd_im
);

    localparam int NA = 1 << AW;
    localparam int NP = 1 << (AW - 1);
    localparam int KW = (AW > 1) ? AW - 1 : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

    state_e                  state_q, state_d;
    logic        [KW-1:0]    k_q, k_d;
    logic        [1:0]       gate_q, gate_d;
    logic        [TW-1:0]    tgt_q, tgt_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic signed [WIDTH-1:0] amp_re_q [NA];
    logic signed [WIDTH-1:0] amp_im_q [NA];
    logic signed [WIDTH-1:0] amp_re_d [NA];
    logic signed [WIDTH-1:0] amp_im_d [NA];

    logic        [AW-1:0]    k_ext, mask, i0, i1;
    logic signed [WIDTH-1:0] b0_re, b0_im, b1_re, b1_im;

    // i0 = k with a zero spliced in at bit 'target'; i1 is its partner with that bit set.
    always_comb begin
        k_ext = AW'(k_q);
        mask  = (AW'(1) << tgt_q) - AW'(1);
        i0    = (k_ext & mask) | ((k_ext & ~mask) << 1);
        i1    = i0 | (AW'(1) << tgt_q);
    end

    pair_gate_alu #(.WIDTH(WIDTH)) u_alu (
        .gate_sel (gate_q),
        .a0_re    (amp_re_q[i0]),
        .a0_im    (amp_im_q[i0]),
        .a1_re    (amp_re_q[i1]),
        .a1_im    (amp_im_q[i1]),
        .b0_re    (b0_re),
        .b0_im    (b0_im),
        .b1_re    (b1_re),
        .b1_im    (b1_im)
    );

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        gate_d   = gate_q;
        tgt_d    = tgt_q;
        err_d    = err_q;
        amp_re_d = amp_re_q;
        amp_im_d = amp_im_q;
        case (state_q)
            S_IDLE: begin
                // The load lands in the same edge as the command latch, so the sweep sees it.
                if (load_valid) begin
                    amp_re_d[load_addr] = load_re;
                    amp_im_d[load_addr] = load_im;
                end
                if (start) begin
                    if (int'(target) < NUM_QUBITS) begin
                        gate_d  = gate_sel;
                        tgt_d   = target;
                        err_d   = 1'b0;
                        k_d     = '0;
                        state_d = S_RUN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end
                end
            end
            S_RUN: begin
                amp_re_d[i0] = b0_re;
                amp_im_d[i0] = b0_im;
                amp_re_d[i1] = b1_re;
                amp_im_d[i1] = b1_im;
                k_d          = k_q + KW'(1);
                if (k_q == KW'(NP - 1)) begin
                    k_d     = '0;
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            gate_q  <= '0;
            tgt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < NA; i++) begin
                amp_re_q[i] <= '0;
                amp_im_q[i] <= '0;
            end
            amp_re_q[0] <= WIDTH'(1 << FRAC);
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            gate_q   <= gate_d;
            tgt_q    <= tgt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            amp_re_q <= amp_re_d;
            amp_im_q <= amp_im_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;
    assign rd_re = amp_re_q[rd_addr];
    assign rd_im = amp_im_q[rd_addr];

endmodule
